avalon_ram_responder: RTL and testbench

- Avalon-MM slave (responder) memory: the bus end that answers the CPU's Avalon master for instruction fetch, load and store.
- Used as the instruction/data RAM in CPU testbenches and as synthesizable on-chip RAM.
- Inserts configurable wait states via waitrequest, applies byteenable on writes, returns registered readdata.
- Flags protocol violations so benches can exercise the master's stall handling.

---
 rtl/avalon_ram_responder_pkg.sv | 11 +
 rtl/avalon_ram_responder_lfsr16.sv | 16 +
 rtl/avalon_ram_responder.sv | 82 ++++++++
 tb/tb_avalon_ram_responder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/avalon_ram_responder_pkg.sv
// avalon_ram_responder_pkg: shared types and constants for the Avalon RAM responder
package avalon_ram_responder_pkg;

   typedef enum logic [0:0] {RAM_IDLE, RAM_STALL} ram_state_t;

   // Fibonacci taps 16,14,13,11 expressed as a mask over value[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC0_0000;

endpackage

// File: rtl/avalon_ram_responder_lfsr16.sv
// avalon_lfsr16: 16-bit Fibonacci LFSR that advances one step per step pulse
module avalon_lfsr16
   import avalon_ram_responder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] value
);

   always_ff @(posedge clk)
      if (reset) value <= seed;
      else if (step) value <= {value[14:0], ^(value & LFSR_TAPS)};

endmodule

// File: rtl/avalon_ram_responder.sv
// avalon_ram_responder: Avalon-MM RAM slave with wait states, byteenable writes and error flags
// Define AVALON_RAM_RANDOM_STALL_EN for LFSR-driven stall lengths in 0..WAIT_CYCLES.
module avalon_ram_responder
   import avalon_ram_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          MEM_WORDS   = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter              INIT_FILE   = "",
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        protocol_error,
   output logic        oob_error
);

   localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;

   ram_state_t    state;
   logic [31:0]   cnt, target, off;
   logic          req, both, accept, in_range;
   logic [IW-1:0] idx;
   logic [31:0]   mem [MEM_WORDS];

   assign req         = read ^ write;
   assign both        = read & write;
   assign off         = address - BASE_ADDR;
   assign in_range    = address >= BASE_ADDR && (off >> 2) < 32'(MEM_WORDS);
   assign idx         = off[IW+1:2];
   assign waitrequest = req && cnt != target;
   assign accept      = req && !waitrequest;

`ifdef AVALON_RAM_RANDOM_STALL_EN
   logic [15:0] lfsr;
   logic [31:0] target_q;
   avalon_lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .step  (accept),
      .value (lfsr)
   );
   // Stall length is drawn in IDLE and held for the rest of the transfer
   assign target = state == RAM_IDLE ? 32'(lfsr) % 32'(WAIT_CYCLES + 1) : target_q;
   always_ff @(posedge clk)
      if (reset) target_q <= '0;
      else if (state == RAM_IDLE && req) target_q <= target;
`else
   assign target = 32'(WAIT_CYCLES);
`endif

   always_ff @(posedge clk)
      if (reset) begin
         state          <= RAM_IDLE;
         cnt            <= '0;
         readdata       <= '0;
         protocol_error <= 1'b0;
         oob_error      <= 1'b0;
      end else begin
         if (both || (state == RAM_STALL && !req)) protocol_error <= 1'b1;
         if (accept && !in_range) oob_error <= 1'b1;
         if (accept && read) readdata <= in_range ? mem[idx] : '0;
         state <= waitrequest ? RAM_STALL : RAM_IDLE;
         cnt   <= waitrequest ? cnt + 32'd1 : '0;
      end

   // Storage has no reset so it maps onto block RAM and survives reset
   always_ff @(posedge clk)
      if (!reset && accept && write && in_range)
         for (int i = 0; i < 4; i++)
            if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];

endmodule

// File: tb/tb_avalon_ram_responder.sv
// tb_avalon_ram_responder: directed self-checking bench for a 3-wait and a 0-wait responder
module tb_avalon_ram_responder;

   logic        clk = 1'b0, reset = 1'b0;
   logic [31:0] address = '0, writedata = '0;
   logic [3:0]  byteenable = '0;
   logic        read3 = 1'b0, write3 = 1'b0, read0 = 1'b0, write0 = 1'b0;
   logic        wait3, wait0, pe3, pe0, oob3, oob0;
   logic [31:0] rd3, rd0;
   int          checks = 0, errors = 0, w0_high = 0, st;

   always #5 clk = ~clk;

   avalon_ram_responder #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .address(address), .read(read3), .write(write3),
      .writedata(writedata), .byteenable(byteenable), .waitrequest(wait3),
      .readdata(rd3), .protocol_error(pe3), .oob_error(oob3));

   avalon_ram_responder #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .read(read0), .write(write0),
      .writedata(writedata), .byteenable(byteenable), .waitrequest(wait0),
      .readdata(rd0), .protocol_error(pe0), .oob_error(oob0));

   always @(negedge clk) begin
      #1;
      if (wait0 !== 1'b0) w0_high++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask

   // sel=1 targets the zero-wait instance; returns the number of waitrequest-high cycles
   task automatic xfer(input bit sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, output int stalls);
      @(negedge clk);
      address = a; writedata = wd; byteenable = be;
      read3 = sel ? 1'b0 : r; write3 = sel ? 1'b0 : w;
      read0 = sel ? r : 1'b0; write0 = sel ? w : 1'b0;
      stalls = 0;
      #1;
      while ((sel ? wait0 : wait3) === 1'b1 && stalls < 20) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      @(posedge clk);
      #1;
      read3 = 1'b0; write3 = 1'b0; read0 = 1'b0; write0 = 1'b0;
   endtask

   task automatic chk_stall(input string tag, input int stalls);
`ifdef AVALON_RAM_RANDOM_STALL_EN
      chk(tag, {31'd0, stalls <= 3}, 32'd1);
`else
      chk(tag, 32'(stalls), 32'd3);
`endif
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_readdata", rd3, 32'h0);
      chk("rst_perr", {31'd0, pe3}, 32'd0);
      chk("rst_oob", {31'd0, oob3}, 32'd0);
      chk("idle_wait", {31'd0, wait3}, 32'd0);

      xfer(0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h2402_0005, 4'hF, st);
      chk_stall("wr_stalls", st);
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, st);
      chk_stall("rd_stalls", st);
      chk("rd_word0", rd3, 32'h2402_0005);

      xfer(0, 1'b0, 1'b1, 32'hBFC0_0004, 32'hAABB_CCDD, 4'hF, st);
      xfer(0, 1'b0, 1'b1, 32'hBFC0_0004, 32'h0000_1100, 4'b0010, st);
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0004, 32'h0, 4'h0, st);
      chk("byte_en_lane1", rd3, 32'hAABB_11DD);
      xfer(0, 1'b0, 1'b1, 32'hBFC0_0006, 32'hFFFF_FFFF, 4'h0, st);
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0007, 32'h0, 4'h0, st);
      chk("byte_en_zero", rd3, 32'hAABB_11DD);

      xfer(0, 1'b0, 1'b1, 32'hBFC0_0FFC, 32'hCAFE_F00D, 4'hF, st);
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0FFC, 32'h0, 4'h0, st);
      chk("last_word", rd3, 32'hCAFE_F00D);
      chk("no_oob_yet", {31'd0, oob3}, 32'd0);

      xfer(0, 1'b1, 1'b0, 32'hBFC0_1000, 32'h0, 4'h0, st);
      chk("oob_rd_data", rd3, 32'h0);
      chk("oob_rd_flag", {31'd0, oob3}, 32'd1);
      xfer(0, 1'b0, 1'b1, 32'hBFC0_1000, 32'hDEAD_BEEF, 4'hF, st);
      xfer(0, 1'b0, 1'b1, 32'hBFBF_FFFC, 32'hDEAD_BEEF, 4'hF, st);
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, st);
      chk("oob_wr_word0", rd3, 32'h2402_0005);
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0FFC, 32'h0, 4'h0, st);
      chk("oob_wr_last", rd3, 32'hCAFE_F00D);

      chk("perr_clear", {31'd0, pe3}, 32'd0);
      @(negedge clk);
      address = 32'hBFC0_0000; writedata = 32'h0; byteenable = 4'hF;
      read3 = 1'b1; write3 = 1'b1;
      #1;
      chk("both_wait", {31'd0, wait3}, 32'd0);
      @(posedge clk);
      #1;
      read3 = 1'b0; write3 = 1'b0;
      chk("both_perr", {31'd0, pe3}, 32'd1);
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, st);
      chk("both_no_write", rd3, 32'h2402_0005);

      @(negedge clk);
      address = 32'hBFC0_0000; writedata = 32'h0; byteenable = 4'hF; write3 = 1'b1;
      @(negedge clk);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) begin reset = 1'b0; write3 = 1'b0; end
      #1;
      chk("midrst_perr", {31'd0, pe3}, 32'd0);
      chk("midrst_oob", {31'd0, oob3}, 32'd0);
      chk("midrst_rd", rd3, 32'h0);
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, st);
      chk_stall("midrst_idle_stalls", st);
      chk("midrst_mem", rd3, 32'h2402_0005);

      @(negedge clk);
      address = 32'hBFC0_0004; read3 = 1'b1;
      @(negedge clk) read3 = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_perr", {31'd0, pe3}, 32'd1);
      chk("drop_rd_hold", rd3, 32'h2402_0005);

      xfer(1, 1'b0, 1'b1, 32'hBFC0_0010, 32'h1122_3344, 4'hF, st);
      chk("w0_wr_stalls", 32'(st), 32'd0);
      xfer(1, 1'b1, 1'b0, 32'hBFC0_0010, 32'h0, 4'h0, st);
      chk("w0_rd_stalls", 32'(st), 32'd0);
      chk("w0_rd_data", rd0, 32'h1122_3344);
      @(negedge clk);
      chk("w0_never_wait", 32'(w0_high), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
